// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU adder-path alignment stage.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    SHIFT,
    OUT
  } state_t;

  // Guard, round and sticky bits appended below the aligned mantissa.
  localparam int unsigned GRS_BITS = 3;

  // Shift distance at or beyond which every mantissa bit lands in the sticky bit.
  function automatic int unsigned sat_limit(input int unsigned mant_width);
    return mant_width + GRS_BITS;
  endfunction

endpackage

// File: rtl/fp_mag_compare.sv
// Magnitude compare of two raw {exp,mant} fields using a ripple subtractor.
module fp_mag_compare #(
  parameter int unsigned MANT_WIDTH = 24,
  parameter int unsigned EXP_WIDTH  = 8
) (
  input  logic [EXP_WIDTH-1:0]  exp_a,
  input  logic [MANT_WIDTH-1:0] mant_a,
  input  logic [EXP_WIDTH-1:0]  exp_b,
  input  logic [MANT_WIDTH-1:0] mant_b,
  output logic                  a_lt_b,
  output logic                  eq,
  output logic [EXP_WIDTH-1:0]  exp_diff
);

  localparam int unsigned W = EXP_WIDTH + MANT_WIDTH;

  logic [W-1:0] a;
  logic [W-1:0] nb;
  logic [W-1:0] diff;
  logic [W:0]   carry;

  assign a        = {exp_a, mant_a};
  assign nb       = ~{exp_b, mant_b};
  assign carry[0] = 1'b1;

  // A + ~B + 1: a carry out of the top bit means A >= B.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i]    = a[i] ^ nb[i] ^ carry[i];
    assign carry[i+1] = (a[i] & nb[i]) | (carry[i] & (a[i] ^ nb[i]));
  end

  assign a_lt_b   = ~carry[W];
  assign eq       = (diff == '0);
  assign exp_diff = a_lt_b ? (exp_b - exp_a) : (exp_a - exp_b);

endmodule

// File: rtl/fp_operand_align.sv
// Orders an operand pair by magnitude and right-aligns the smaller mantissa
// into a {mant,G,R,S} field with an iterative sticky-preserving shifter.
module fp_operand_align
  import fpu_pkg::*;
#(
  parameter int unsigned MANT_WIDTH = 24,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           sign_a,
  input  logic                           sign_b,
  input  logic [EXP_WIDTH-1:0]           exp_a,
  input  logic [EXP_WIDTH-1:0]           exp_b,
  input  logic [MANT_WIDTH-1:0]          mant_a,
  input  logic [MANT_WIDTH-1:0]          mant_b,
  input  logic                           op_sub,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [MANT_WIDTH-1:0]          big_mant,
  output logic [MANT_WIDTH+GRS_BITS-1:0] small_mant_ext,
  output logic [EXP_WIDTH-1:0]           res_exp,
  output logic                           res_sign,
  output logic                           eff_sub,
  output logic                           swapped,
  output logic                           equal_mag
);

  localparam int unsigned SW  = MANT_WIDTH + GRS_BITS;
  localparam int unsigned SAT = sat_limit(MANT_WIDTH);

  state_t state, next_state;

  logic                  sa_q, sb_q, op_q;
  logic [EXP_WIDTH-1:0]  ea_q, eb_q;
  logic [MANT_WIDTH-1:0] ma_q, mb_q;
  logic [SW-1:0]         shreg;
  logic [EXP_WIDTH-1:0]  rem;

  logic                  a_lt_b, eq;
  logic [EXP_WIDTH-1:0]  exp_diff;

  logic                  sat;
  int unsigned           k;
  logic [SW-1:0]         lost;
  logic [SW-1:0]         shifted;
  logic [SW-1:0]         shift_next;
  logic [EXP_WIDTH-1:0]  rem_next;

  fp_mag_compare #(
    .MANT_WIDTH(MANT_WIDTH),
    .EXP_WIDTH (EXP_WIDTH)
  ) u_cmp (
    .exp_a   (ea_q),
    .mant_a  (ma_q),
    .exp_b   (eb_q),
    .mant_b  (mb_q),
    .a_lt_b  (a_lt_b),
    .eq      (eq),
    .exp_diff(exp_diff)
  );

  assign small_mant_ext = shreg;

  // One shifter step: saturate to sticky-only, or shift by up to SHIFT_STEP
  // folding every bit that falls off the bottom into the sticky position.
  always_comb begin
    sat        = (32'(rem) >= SAT);
    k          = (32'(rem) < SHIFT_STEP) ? 32'(rem) : SHIFT_STEP;
    lost       = shreg & ~({SW{1'b1}} << k);
    shifted    = shreg >> k;
    shift_next = {shifted[SW-1:1], shifted[0] | (|lost)};
    rem_next   = rem - EXP_WIDTH'(k);
    if (sat) begin
      shift_next = {{(SW-1){1'b0}}, |shreg};
      rem_next   = '0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = CMP;
      end
      CMP:   next_state = (exp_diff == '0) ? OUT : SHIFT;
      SHIFT: if (rem_next == '0) next_state = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, ordering and alignment datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      op_q      <= 1'b0;
      ea_q      <= '0;
      eb_q      <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      shreg     <= '0;
      rem       <= '0;
      big_mant  <= '0;
      res_exp   <= '0;
      res_sign  <= 1'b0;
      eff_sub   <= 1'b0;
      swapped   <= 1'b0;
      equal_mag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa_q <= sign_a;
          sb_q <= sign_b;
          op_q <= op_sub;
          ea_q <= exp_a;
          eb_q <= exp_b;
          ma_q <= mant_a;
          mb_q <= mant_b;
        end
        CMP: begin
          big_mant  <= a_lt_b ? mb_q : ma_q;
          shreg     <= {(a_lt_b ? ma_q : mb_q), {GRS_BITS{1'b0}}};
          rem       <= exp_diff;
          res_exp   <= a_lt_b ? eb_q : ea_q;
          res_sign  <= a_lt_b ? (sb_q ^ op_q) : sa_q;
          eff_sub   <= op_q ^ sa_q ^ sb_q;
          swapped   <= a_lt_b;
          equal_mag <= eq;
        end
        SHIFT: begin
          shreg <= shift_next;
          rem   <= rem_next;
        end
        default: ;
      endcase
    end
  end

endmodule
